legofpga_link_checker: RTL
==========================

# legofpga_link_checker

Self-checking link sanity engine for the QSFP MAC loopback design. It sits on the MAC user-side RX AXI-Stream, downstream of the 25GE MAC/PCS, beside the TX packet generator. It sequences link bring-up, kicks the generator, and checks received frames for pattern, protocol and count integrity. It then latches a 5-bit `completion_status` verdict for the bench or LEDs.

## Interface
Parameters:
- `CNT_W`, 32: width of packet and byte counters.
- `LOCK_TO_W`, 21: lock and align timeout is 2^LOCK_TO_W cycles.
- `TX_TO`, 1_000_000: cycles allowed from `tx_start` to `tx_done`.
- `DRAIN_CYC`, 1024: idle RX cycles allowed before a forced verdict.

Ports:
- `dclk` in 1: single clock. All logic is synchronous to it.
- `sys_resetn` in 1: reset, asynchronous and active-low.
- `restart` in 1: level; sampled only in DONE.
- `rx_block_lock` in 1: PCS block lock, synchronous to `dclk`.
- `rx_status` in 1: PCS aligned/status.
- `tx_start` out 1: one-cycle pulse to the generator.
- `tx_done` in 1: one-cycle pulse from the generator.
- `tx_pkt_cnt` in CNT_W: generator packet total, valid with `tx_done`.
- `tx_byte_cnt` in CNT_W: generator byte total, valid with `tx_done`.
- `rx_tvalid` in 1: RX beat valid. There is no backpressure.
- `rx_tdata` in 64: RX data. Byte 0 is `[7:0]`.
- `rx_tkeep` in 8: RX byte enables.
- `rx_tlast` in 1: last beat of a frame.
- `rx_tuser` in 1: frame error, meaningful on the last beat.
- `rx_pkt_cnt` out CNT_W: frames received.
- `rx_byte_cnt` out CNT_W: bytes received.
- `completion_status` out 5: verdict code.

## Operation
- **States and transitions:**
  - WAIT_LOCK → WAIT_ALIGN on `rx_block_lock`.
  - WAIT_ALIGN → RUN on `rx_status`.
  - RUN → DRAIN on `tx_done`.
  - DRAIN → DONE when the verdict is ready.
  - Reset enters WAIT_LOCK.
- **Status codes:**
  - 0x1F during reset.
  - 0x00 while in WAIT_LOCK, WAIT_ALIGN, RUN or DRAIN.
  - Final code latched in DONE.
- **Timeouts.** The timeout counter clears on every state change.
  - WAIT_LOCK timeout → DONE, code 2.
  - WAIT_ALIGN timeout → DONE, code 8.
  - RUN with no `tx_done` within TX_TO → DONE, code 10.
- **Link loss in RUN or DRAIN:**
  - `rx_block_lock` low → DONE, code 4.
  - `rx_status` low → DONE, code 9.
  - Both low in the same cycle → code 4.
- **RX checking.** Beats are counted only in RUN and DRAIN; beats in other states are ignored.
  - Expected payload: byte k of a frame equals k mod 256, with k counted from frame start.
  - Any mismatch in an enabled byte sets sticky `bit_err`.
  - `rx_tuser` high on a last beat also sets `bit_err`.
  - Protocol errors set sticky `proto_err`:
    - `rx_tkeep` ≠ 0xFF on a non-last beat;
    - non-contiguous `rx_tkeep` on a last beat (it must be 2^n−1, n = 1..8);
    - `rx_tkeep` = 0 with `rx_tvalid`.
  - `rx_byte_cnt` adds popcount(`rx_tkeep`) per beat.
  - `rx_pkt_cnt` increments on `rx_tlast`.
- **DRAIN.** The TX totals are latched on `tx_done`. DRAIN ends when either:
  - `rx_pkt_cnt` equals the latched packet total and no frame is open; or
  - DRAIN_CYC consecutive cycles pass without `rx_tvalid`.
- **Verdict priority (highest first):**
  1. latched `tx_pkt_cnt` = 0 → 11
  2. `proto_err` → 14
  3. `bit_err` → 15
  4. packet mismatch → 12
  5. byte mismatch → 13
  6. otherwise → 1
- **Restart.** `restart` high in DONE:
  - clears counters, sticky flags and open-frame state;
  - sets status to 0x00;
  - goes to WAIT_ALIGN if `rx_block_lock` is high, else WAIT_LOCK.
  - `restart` in any other state is ignored.

## Timing
- All outputs are registered.
- Reset values: `completion_status` 0x1F, `tx_start` 0, counters 0.
- `tx_start` pulses high in the first cycle of RUN, one cycle after `rx_status` is sampled high.
- Counters and sticky flags reflect a beat 1 cycle after it.
- `completion_status` changes in the cycle DONE is entered, 1 cycle after the deciding event.
- A `tx_done` and an RX beat in the same cycle: the beat is counted.
- Reset assertion mid-frame takes effect immediately and asynchronously. Deassertion is used synchronously via a 2-flop synchronizer inside the block.

## Structure
- Package `legofpga_link_pkg`:
  - `link_state_t` enum;
  - `localparam` status codes (ST_PASS = 1, ST_NO_LOCK = 2, … ST_RESET = 31);
  - `popcount8` function.
- Sub-module `legofpga_rx_pattern_chk`:
  - per-beat payload, keep and open-frame checking;
  - outputs `bit_err`, `proto_err`, `beat_bytes`, `frame_open`;
  - clear input driven on restart.

## Test plan
- **Clean run.** Stimulus: lock, then align, then 10 frames of 64 B; `tx_done` with 10 / 640.
  - Required: `tx_start` 1 cycle after align; status 1; `rx_pkt_cnt` 10; `rx_byte_cnt` 640.
- **No lock.** Stimulus: `rx_block_lock` held low, LOCK_TO_W = 8.
  - Required: status 2 after 256 cycles.
- **Corrupted byte.** Stimulus: byte 5 of frame 3 is wrong.
  - Required: status 15.
- **Bad keep.** Stimulus: `rx_tkeep` 0x7F on a non-last beat.
  - Required: status 14, even when counts match.
- **Link loss.** Stimulus: `rx_status` drops during RUN.
  - Required: status 9; a simultaneous lock drop gives 4.
- **Restart and short run.**
  - Stimulus: `restart` in DONE, then 9 of 10 frames received.
  - Required: status 0x00 next cycle, counters cleared.
  - Required: status 12 after DRAIN_CYC idle cycles.

Source files
------------

// File: rtl/legofpga_link_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// legofpga_link_pkg : link-checker states, verdict codes, popcount helper
// Rev 1.0
// ----------------------------------------------------------------------------
package legofpga_link_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    WAIT_ALIGN = 3'd1,
    RUN        = 3'd2,
    DRAIN      = 3'd3,
    DONE       = 3'd4
  } link_state_t;

  localparam logic [4:0] ST_RUNNING       = 5'd0;
  localparam logic [4:0] ST_PASS          = 5'd1;
  localparam logic [4:0] ST_NO_LOCK       = 5'd2;
  localparam logic [4:0] ST_LOCK_LOST     = 5'd4;
  localparam logic [4:0] ST_NO_ALIGN      = 5'd8;
  localparam logic [4:0] ST_ALIGN_LOST    = 5'd9;
  localparam logic [4:0] ST_TX_TIMEOUT    = 5'd10;
  localparam logic [4:0] ST_NO_TX         = 5'd11;
  localparam logic [4:0] ST_PKT_MISMATCH  = 5'd12;
  localparam logic [4:0] ST_BYTE_MISMATCH = 5'd13;
  localparam logic [4:0] ST_PROTO_ERR     = 5'd14;
  localparam logic [4:0] ST_BIT_ERR       = 5'd15;
  localparam logic [4:0] ST_RESET         = 5'd31;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/legofpga_rx_pattern_chk.sv
`default_nettype none
// ----------------------------------------------------------------------------
// legofpga_rx_pattern_chk : per-beat payload / tkeep / open-frame checker
// Rev 1.0
// ----------------------------------------------------------------------------
module legofpga_rx_pattern_chk
  import legofpga_link_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        beat_en,
  input  logic [63:0] tdata,
  input  logic [7:0]  tkeep,
  input  logic        tlast,
  input  logic        tuser,
  output logic        bit_err,
  output logic        proto_err,
  output logic [3:0]  beat_bytes,
  output logic        frame_open
);

  logic [7:0] offset;
  logic       data_bad;
  logic       keep_bad;

  // Byte k of a frame carries k mod 256; offset is the index of lane 0.
  always_comb begin
    data_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (tkeep[i] && (tdata[8*i +: 8] != (offset + 8'(i)))) data_bad = 1'b1;
    end
  end

  // A legal last-beat keep is 2^n-1: adding one leaves no overlapping bit.
  assign keep_bad = (tkeep == 8'h00)
                 || (!tlast && (tkeep != 8'hFF))
                 || (tlast && ((tkeep & (tkeep + 8'd1)) != 8'h00));

  assign beat_bytes = popcount8(tkeep);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset     <= 8'd0;
      bit_err    <= 1'b0;
      proto_err  <= 1'b0;
      frame_open <= 1'b0;
    end else if (clear) begin
      offset     <= 8'd0;
      bit_err    <= 1'b0;
      proto_err  <= 1'b0;
      frame_open <= 1'b0;
    end else if (beat_en) begin
      if (data_bad || (tlast && tuser)) bit_err <= 1'b1;
      if (keep_bad) proto_err <= 1'b1;
      if (tlast) begin
        offset     <= 8'd0;
        frame_open <= 1'b0;
      end else begin
        offset     <= offset + 8'd8;
        frame_open <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/legofpga_link_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// legofpga_link_checker : link bring-up sequencer and RX frame verdict engine
// Rev 1.0
// ----------------------------------------------------------------------------
module legofpga_link_checker
  import legofpga_link_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int LOCK_TO_W = 21,
  parameter int TX_TO     = 1_000_000,
  parameter int DRAIN_CYC = 1024
) (
  input  logic             dclk,
  input  logic             sys_resetn,
  input  logic             restart,
  input  logic             rx_block_lock,
  input  logic             rx_status,
  output logic             tx_start,
  input  logic             tx_done,
  input  logic [CNT_W-1:0] tx_pkt_cnt,
  input  logic [CNT_W-1:0] tx_byte_cnt,
  input  logic             rx_tvalid,
  input  logic [63:0]      rx_tdata,
  input  logic [7:0]       rx_tkeep,
  input  logic             rx_tlast,
  input  logic             rx_tuser,
  output logic [CNT_W-1:0] rx_pkt_cnt,
  output logic [CNT_W-1:0] rx_byte_cnt,
  output logic [4:0]       completion_status
);

  localparam logic [31:0] LOCK_LIM  = 32'((64'd1 << LOCK_TO_W) - 64'd1);
  localparam logic [31:0] TX_LIM    = 32'(TX_TO - 1);
  localparam logic [31:0] DRAIN_LIM = 32'(DRAIN_CYC - 1);

  logic [1:0]       rst_sync;
  logic             rst_n;
  link_state_t      state;
  logic [31:0]      tmo_cnt;
  logic [31:0]      idle_cnt;
  logic [CNT_W-1:0] tx_pkt_lat;
  logic [CNT_W-1:0] tx_byte_lat;
  logic             clear;
  logic             beat_en;
  logic             bit_err;
  logic             proto_err;
  logic             frame_open;
  logic [3:0]       beat_bytes;
  logic             drain_done;
  logic [4:0]       verdict;

  // Assertion is immediate; release is retimed onto dclk.
  always_ff @(posedge dclk or negedge sys_resetn) begin
    if (!sys_resetn) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign clear      = (state == DONE) && restart;
  assign beat_en    = rx_tvalid && ((state == RUN) || (state == DRAIN));
  assign drain_done = ((rx_pkt_cnt == tx_pkt_lat) && !frame_open)
                   || (!rx_tvalid && (idle_cnt == DRAIN_LIM));

  always_comb begin
    verdict = ST_PASS;
    if (tx_pkt_lat == '0)               verdict = ST_NO_TX;
    else if (proto_err)                 verdict = ST_PROTO_ERR;
    else if (bit_err)                   verdict = ST_BIT_ERR;
    else if (rx_pkt_cnt != tx_pkt_lat)  verdict = ST_PKT_MISMATCH;
    else if (rx_byte_cnt != tx_byte_lat) verdict = ST_BYTE_MISMATCH;
  end

  legofpga_rx_pattern_chk u_pattern_chk (
    .clk        (dclk),
    .rst_n      (rst_n),
    .clear      (clear),
    .beat_en    (beat_en),
    .tdata      (rx_tdata),
    .tkeep      (rx_tkeep),
    .tlast      (rx_tlast),
    .tuser      (rx_tuser),
    .bit_err    (bit_err),
    .proto_err  (proto_err),
    .beat_bytes (beat_bytes),
    .frame_open (frame_open)
  );

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= WAIT_LOCK;
      tmo_cnt           <= '0;
      idle_cnt          <= '0;
      tx_pkt_lat        <= '0;
      tx_byte_lat       <= '0;
      tx_start          <= 1'b0;
      completion_status <= ST_RESET;
    end else begin
      tx_start <= 1'b0;
      tmo_cnt  <= tmo_cnt + 32'd1;
      idle_cnt <= ((state == DRAIN) && !rx_tvalid) ? idle_cnt + 32'd1 : '0;
      case (state)
        WAIT_LOCK: begin
          completion_status <= ST_RUNNING;
          if (rx_block_lock) begin
            state <= WAIT_ALIGN; tmo_cnt <= '0;
          end else if (tmo_cnt == LOCK_LIM) begin
            state <= DONE; tmo_cnt <= '0; completion_status <= ST_NO_LOCK;
          end
        end
        WAIT_ALIGN: begin
          completion_status <= ST_RUNNING;
          if (rx_status) begin
            state <= RUN; tmo_cnt <= '0; tx_start <= 1'b1;
          end else if (tmo_cnt == LOCK_LIM) begin
            state <= DONE; tmo_cnt <= '0; completion_status <= ST_NO_ALIGN;
          end
        end
        RUN, DRAIN: begin
          completion_status <= ST_RUNNING;
          // Lock loss outranks alignment loss when both drop together.
          if (!rx_block_lock) begin
            state <= DONE; tmo_cnt <= '0; completion_status <= ST_LOCK_LOST;
          end else if (!rx_status) begin
            state <= DONE; tmo_cnt <= '0; completion_status <= ST_ALIGN_LOST;
          end else if (state == RUN) begin
            if (tx_done) begin
              state <= DRAIN; tmo_cnt <= '0;
              tx_pkt_lat  <= tx_pkt_cnt;
              tx_byte_lat <= tx_byte_cnt;
            end else if (tmo_cnt == TX_LIM) begin
              state <= DONE; tmo_cnt <= '0; completion_status <= ST_TX_TIMEOUT;
            end
          end else if (drain_done) begin
            state <= DONE; tmo_cnt <= '0; completion_status <= verdict;
          end
        end
        DONE: begin
          if (restart) begin
            state             <= rx_block_lock ? WAIT_ALIGN : WAIT_LOCK;
            tmo_cnt           <= '0;
            completion_status <= ST_RUNNING;
          end
        end
        default: begin
          state <= WAIT_LOCK; tmo_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_pkt_cnt  <= '0;
      rx_byte_cnt <= '0;
    end else if (clear) begin
      rx_pkt_cnt  <= '0;
      rx_byte_cnt <= '0;
    end else if (beat_en) begin
      rx_byte_cnt <= rx_byte_cnt + {{(CNT_W-4){1'b0}}, beat_bytes};
      if (rx_tlast) rx_pkt_cnt <= rx_pkt_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire
